// File: rtl/speed_pkg.sv
// -----------------------------------------------------------------------------
// speed_pkg
// Shared types and constants for the speed divider: the control state enum,
// default parameter values and the fixed datapath widths.
// No ports.
// -----------------------------------------------------------------------------
package speed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SAT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 12 MHz clock x 30 cm gate distance: quotient comes out in cm/s
  localparam logic [31:0] DIVIDEND_DEFAULT  = 32'd360_000_000;
  localparam int          TICK_W_DEFAULT    = 24;
  localparam int          SPEED_MAX_DEFAULT = 99;

  localparam int SPEED_W   = 7;
  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/bin2bcd7.sv
// -----------------------------------------------------------------------------
// bin2bcd7
// Combinational 7-bit binary (0..99) to two BCD digits. The parent registers
// the result. Inputs above 99 clamp the tens digit at 9 and are not expected.
// Ports:
//   i_bin   in  7  binary value 0..99
//   o_tens  out 4  tens digit
//   o_ones  out 4  ones digit
// -----------------------------------------------------------------------------
module bin2bcd7
  import speed_pkg::*;
(
  input  logic [SPEED_W-1:0] i_bin,
  output logic [3:0]         o_tens,
  output logic [3:0]         o_ones
);

  logic [3:0]         w_tens;
  logic [SPEED_W-1:0] w_tens_x10;
  logic [SPEED_W-1:0] w_ones;

  // Compare ladder instead of a divide: the last threshold met wins.
  always_comb begin
    w_tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (i_bin >= SPEED_W'(10 * i)) begin
        w_tens = 4'(i);
      end
    end
  end

  assign w_tens_x10 = SPEED_W'(w_tens) * SPEED_W'(10);
  assign w_ones     = i_bin - w_tens_x10;

  assign o_tens = w_tens;
  assign o_ones = w_ones[3:0];

endmodule

// File: rtl/speed_divider.sv
// -----------------------------------------------------------------------------
// speed_divider
// Sequential divide-and-saturate stage between the sensor time counter and the
// seven-segment display. Computes DIVIDEND / ticks with a 32-step restoring
// divider, clamps to SPEED_MAX and presents the result with a one-cycle strobe.
// Optional feature macro: SPEED_DIVIDER_BCD_EN -- when defined, registered BCD
// digits are produced; otherwise bcd_tens/bcd_ones are tied to 0.
// Ports:
//   clk       in   1       system clock, 12 MHz
//   rst       in   1       asynchronous active-high reset
//   start     in   1       one-cycle pulse, new measurement on ticks
//   ticks     in   TICK_W  transit time, sampled on an accepted start
//   busy      out  1       division in progress (state != IDLE)
//   valid     out  1       one-cycle strobe, result outputs updated
//   speed     out  7       saturated speed, held between strobes
//   sat       out  1       last result was clamped
//   bcd_tens  out  4       tens digit of speed
//   bcd_ones  out  4       ones digit of speed
// Timing: accept at edge N, valid after edge N+34, next accept at N+35.
// -----------------------------------------------------------------------------
module speed_divider
  import speed_pkg::*;
#(
  parameter logic [31:0] DIVIDEND  = DIVIDEND_DEFAULT,
  parameter int          TICK_W    = TICK_W_DEFAULT,
  parameter int          SPEED_MAX = SPEED_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TICK_W-1:0] ticks,
  output logic              busy,
  output logic              valid,
  output logic [6:0]        speed,
  output logic              sat,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_ones
);

  state_t               r_state;
  logic [TICK_W-1:0]    r_div;
  logic [DIV_STEPS-1:0] r_dvd;
  logic [DIV_STEPS-1:0] r_q;
  logic [TICK_W:0]      r_rem;
  logic [4:0]           r_cnt;
  logic                 r_zero;

  logic [SPEED_W-1:0]   r_speed_stg;
  logic                 r_sat_stg;
  logic [SPEED_W-1:0]   r_speed;
  logic                 r_sat;
  logic                 r_valid;

  logic [TICK_W:0]      w_rem_sh;
  logic [TICK_W:0]      w_rem_diff;
  logic                 w_ge;
  logic                 w_over;
  logic [SPEED_W-1:0]   w_sat_speed;

  // One restoring step: bring down the next dividend bit, then trial-subtract.
  assign w_rem_sh   = {r_rem[TICK_W-1:0], r_dvd[DIV_STEPS-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_diff = w_rem_sh - {1'b0, r_div};

  assign w_over      = r_zero || (r_q > DIV_STEPS'(SPEED_MAX));
  assign w_sat_speed = w_over ? SPEED_W'(SPEED_MAX) : r_q[SPEED_W-1:0];

`ifdef SPEED_DIVIDER_BCD_EN
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] r_tens_stg;
  logic [3:0] r_ones_stg;
  logic [3:0] r_bcd_tens;
  logic [3:0] r_bcd_ones;

  bin2bcd7 u_bin2bcd7 (
    .i_bin  (w_sat_speed),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens_stg <= 4'd0;
      r_ones_stg <= 4'd0;
      r_bcd_tens <= 4'd0;
      r_bcd_ones <= 4'd0;
    end else if (r_state == SAT) begin
      r_tens_stg <= w_tens;
      r_ones_stg <= w_ones;
    end else if (r_state == DONE) begin
      r_bcd_tens <= r_tens_stg;
      r_bcd_ones <= r_ones_stg;
    end
  end

  assign bcd_tens = r_bcd_tens;
  assign bcd_ones = r_bcd_ones;
`else
  assign bcd_tens = 4'd0;
  assign bcd_ones = 4'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_dvd       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_speed_stg <= '0;
      r_sat_stg   <= 1'b0;
      r_speed     <= '0;
      r_sat       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div   <= ticks;
            r_dvd   <= DIVIDEND;
            r_q     <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_zero  <= (ticks == '0);
            r_state <= DIV;
          end
        end
        DIV: begin
          r_rem <= w_ge ? w_rem_diff : w_rem_sh;
          // A zero divisor forces all-ones so the result always saturates,
          // while the step count (and thus latency) stays the same.
          r_q   <= {r_q[DIV_STEPS-2:0], (w_ge | r_zero)};
          r_dvd <= {r_dvd[DIV_STEPS-2:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(DIV_STEPS - 1)) begin
            r_state <= SAT;
          end
        end
        SAT: begin
          r_speed_stg <= w_sat_speed;
          r_sat_stg   <= w_over;
          r_state     <= DONE;
        end
        DONE: begin
          // Staged values land on the outputs together with the strobe.
          r_speed <= r_speed_stg;
          r_sat   <= r_sat_stg;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign valid = r_valid;
  assign speed = r_speed;
  assign sat   = r_sat;

endmodule

// File: tb/tb_speed_divider.sv
module tb_speed_divider;

  localparam longint DIVIDEND  = 360_000_000;
  localparam int     SPEED_MAX = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] ticks = 24'd0;
  logic        busy;
  logic        valid;
  logic [6:0]  speed;
  logic        sat;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;

  int checks   = 0;
  int failures = 0;
  int prev_speed = 0;

  speed_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ticks    (ticks),
    .busy     (busy),
    .valid    (valid),
    .speed    (speed),
    .sat      (sat),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division from the rules, then clamp.
  function automatic int model_speed(input logic [23:0] t);
    longint q;
    if (t == 24'd0) return SPEED_MAX;
    q = DIVIDEND / longint'(t);
    return (q > SPEED_MAX) ? SPEED_MAX : int'(q);
  endfunction

  function automatic int model_sat(input logic [23:0] t);
    if (t == 24'd0) return 1;
    return ((DIVIDEND / longint'(t)) > SPEED_MAX) ? 1 : 0;
  endfunction

  task automatic chk_result(input string tag, input logic [23:0] t);
    int es;
    es = model_speed(t);
    chk({tag, "_speed"}, 32'(speed), 32'(es));
    chk({tag, "_sat"}, 32'(sat), 32'(model_sat(t)));
`ifdef SPEED_DIVIDER_BCD_EN
    chk({tag, "_tens"}, 32'(bcd_tens), 32'(es / 10));
    chk({tag, "_ones"}, 32'(bcd_ones), 32'(es % 10));
`else
    chk({tag, "_tens"}, 32'(bcd_tens), 32'd0);
    chk({tag, "_ones"}, 32'(bcd_ones), 32'd0);
`endif
  endtask

  // One full measurement: pulse start, scramble ticks while busy, time the strobe.
  task automatic run_one(input string tag, input logic [23:0] t);
    int lat;
    lat = -1;
    @(negedge clk);
    ticks = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    ticks = 24'($urandom);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = i;
        break;
      end
      if (i == 20) chk({tag, "_hold"}, 32'(speed), 32'(prev_speed));
    end
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk_result(tag, t);
    @(posedge clk);
    #1;
    chk({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    prev_speed = model_speed(t);
  endtask

  initial begin
    int vq[$];
    int nval;
    logic [23:0] rt;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_speed", 32'(speed), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_bcd", 32'({bcd_tens, bcd_ones}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed points
    run_one("t12M", 24'd12_000_000);
    run_one("t7M2", 24'd7_200_000);
    run_one("tmax", 24'd16_777_215);
    run_one("t3M6", 24'd3_600_000);
    run_one("tzero", 24'd0);
    run_one("t1", 24'd1);

    // Randomized points, mix of saturating and in-range transit times
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) rt = 24'($urandom_range(0, 4_000_000));
      else            rt = 24'($urandom_range(3_600_001, 16_777_215));
      run_one("rand", rt);
    end

    // Start held high for 40 cycles: accepts at N and N+35 only
    @(negedge clk);
    ticks = 24'd7_200_000;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (valid) vq.push_back(i);
      if (i == 39) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk("held_nvalid", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      chk("held_first", 32'(vq[0]), 32'd34);
      chk("held_second", 32'(vq[1]), 32'd69);
    end
    chk("held_speed", 32'(speed), 32'd50);
    prev_speed = 50;

    // Reset in the middle of the division
    @(negedge clk);
    ticks = 24'd12_000_000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_speed", 32'(speed), 32'd0);
    chk("mid_rst_sat", 32'(sat), 32'd0);
    chk("mid_rst_bcd", 32'({bcd_tens, bcd_ones}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) nval++;
    end
    chk("mid_rst_no_valid", 32'(nval), 32'd0);
    prev_speed = 0;
    run_one("post_rst", 24'd12_000_000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
